// File: rtl/rect_blitter.sv
// Rectangle rasteriser: accepts one origin/size/colour request and emits one pixel per clock,
// row-major, on the adapter's x/y/colour/plot port. Define RECT_BLITTER_CLIP_EN to suppress off-screen pixels.
module rect_blitter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SIZE_W   = 4,
    parameter int H_RES    = 160,
    parameter int V_RES    = 120
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [X_W-1:0]      req_x,
    input  logic [Y_W-1:0]      req_y,
    input  logic [SIZE_W-1:0]   req_w_m1,
    input  logic [SIZE_W-1:0]   req_h_m1,
    input  logic [COLOUR_W-1:0] req_colour,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [X_W-1:0]      base_x_q, base_x_d;
    logic [Y_W-1:0]      base_y_q, base_y_d;
    logic [SIZE_W-1:0]   w_m1_q, w_m1_d;
    logic [SIZE_W-1:0]   h_m1_q, h_m1_d;
    logic [COLOUR_W-1:0] fill_q, fill_d;
    logic [SIZE_W-1:0]   cx_q, cx_d;
    logic [SIZE_W-1:0]   cy_q, cy_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                done_q, done_d;

    // Pixel about to be registered onto the adapter port this edge.
    logic                pix_en;
    logic [X_W-1:0]      pix_base_x;
    logic [Y_W-1:0]      pix_base_y;
    logic [SIZE_W-1:0]   pix_cx;
    logic [SIZE_W-1:0]   pix_cy;
    logic [COLOUR_W-1:0] pix_colour;
    logic [X_W-1:0]      pix_x;
    logic [Y_W-1:0]      pix_y;
    logic                pix_vis;

    if (H_RES < 1 || V_RES < 1) begin : g_res_check
        $error("rect_blitter: H_RES and V_RES must be positive");
    end

    always_comb begin
        state_d    = state_q;
        base_x_d   = base_x_q;
        base_y_d   = base_y_q;
        w_m1_d     = w_m1_q;
        h_m1_d     = h_m1_q;
        fill_d     = fill_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        done_d     = 1'b0;
        pix_en     = 1'b0;
        pix_base_x = base_x_q;
        pix_base_y = base_y_q;
        pix_cx     = cx_q;
        pix_cy     = cy_q;
        pix_colour = fill_q;
        unique case (state_q)
            ST_IDLE: begin
                // The first pixel goes out straight from the request so it appears the cycle after accept.
                if (req_valid) begin
                    state_d    = ST_RUN;
                    base_x_d   = req_x;
                    base_y_d   = req_y;
                    w_m1_d     = req_w_m1;
                    h_m1_d     = req_h_m1;
                    fill_d     = req_colour;
                    cx_d       = '0;
                    cy_d       = '0;
                    pix_en     = 1'b1;
                    pix_base_x = req_x;
                    pix_base_y = req_y;
                    pix_cx     = '0;
                    pix_cy     = '0;
                    pix_colour = req_colour;
                end
            end
            ST_RUN: begin
                if (cx_q == w_m1_q && cy_q == h_m1_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (cx_q == w_m1_q) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                    pix_en = 1'b1;
                    pix_cx = cx_d;
                    pix_cy = cy_d;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef RECT_BLITTER_CLIP_EN
    localparam logic [X_W:0] H_LIM = (X_W+1)'(H_RES);
    localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_RES);
    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;
    // One extra bit so a sum past the port width counts as off-screen instead of wrapping.
    assign sum_x   = {1'b0, pix_base_x} + (X_W+1)'(pix_cx);
    assign sum_y   = {1'b0, pix_base_y} + (Y_W+1)'(pix_cy);
    assign pix_x   = sum_x[X_W-1:0];
    assign pix_y   = sum_y[Y_W-1:0];
    assign pix_vis = (sum_x < H_LIM) && (sum_y < V_LIM);
`else
    assign pix_x   = pix_base_x + X_W'(pix_cx);
    assign pix_y   = pix_base_y + Y_W'(pix_cy);
    assign pix_vis = 1'b1;
`endif

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        if (pix_en) begin
            x_d      = pix_x;
            y_d      = pix_y;
            colour_d = pix_colour;
            plot_d   = pix_vis;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            base_x_q <= '0;
            base_y_q <= '0;
            w_m1_q   <= '0;
            h_m1_q   <= '0;
            fill_q   <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            w_m1_q   <= w_m1_d;
            h_m1_q   <= h_m1_d;
            fill_q   <= fill_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rect_blitter.sv
// Directed and random rectangle requests checked cycle by cycle against a row-major pixel model
// computed from origin/size with plain arithmetic.
module tb_rect_blitter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_x = '0;
    logic [6:0] req_y = '0;
    logic [3:0] req_w_m1 = '0;
    logic [3:0] req_h_m1 = '0;
    logic [2:0] req_colour = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    rect_blitter dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_w_m1(req_w_m1), .req_h_m1(req_h_m1),
        .req_colour(req_colour),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int bx, input int by, input int w, input int h, input int c);
        req_x      = 8'(bx);
        req_y      = 7'(by);
        req_w_m1   = 4'(w);
        req_h_m1   = 4'(h);
        req_colour = 3'(c);
    endtask

    task automatic issue(input int bx, input int by, input int w, input int h, input int c);
        for (int i = 0; i < 1000 && !req_ready; i++) step();
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
        present(bx, by, w, h, c);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    // Entered in the first cycle after the accepting edge; leaves in the cycle where req_ready returns.
    task automatic expect_rect(input int bx, input int by, input int w, input int h, input int c);
        int  p;
        int  sx, sy, ex, ey;
        int  ev;
        p = (w + 1) * (h + 1);
        ex = 0;
        ey = 0;
        for (int i = 0; i < p; i++) begin
            sx = bx + i % (w + 1);
            sy = by + i / (w + 1);
            ex = sx % 256;
            ey = sy % 128;
`ifdef RECT_BLITTER_CLIP_EN
            ev = (sx < 160 && sy < 120) ? 1 : 0;
`else
            ev = 1;
`endif
            chk($sformatf("px%0d_x", i), {24'd0, x}, ex);
            chk($sformatf("px%0d_y", i), {25'd0, y}, ey);
            chk($sformatf("px%0d_colour", i), {29'd0, colour}, c);
            chk($sformatf("px%0d_plot", i), {31'd0, plot}, ev);
            chk($sformatf("px%0d_busy", i), {30'd0, busy, done}, 32'd2);
            step();
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_plot", {31'd0, plot}, 32'd0);
        chk("done_ready", {30'd0, req_ready, busy}, 32'd0);
        chk("hold_x", {24'd0, x}, ex);
        chk("hold_y", {25'd0, y}, ey);
        step();
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_done", {30'd0, done, plot}, 32'd0);
        $display("rect (%0d,%0d) %0dx%0d colour %0d: %0d pixels, errors so far %0d",
                 bx, by, w + 1, h + 1, c, p, errors);
    endtask

    initial begin
        int rx, ry, rw, rh, rc;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy_done_plot", {29'd0, busy, done, plot}, 32'd0);
        chk("rst_x", {24'd0, x}, 32'd0);
        chk("rst_y", {25'd0, y}, 32'd0);
        chk("rst_colour", {29'd0, colour}, 32'd0);
        resetn = 1'b1;
        step();
        chk("idle_plot", {31'd0, plot}, 32'd0);

        issue(10, 20, 2, 1, 7);
        expect_rect(10, 20, 2, 1, 7);

        issue(0, 0, 0, 0, 0);
        expect_rect(0, 0, 0, 0, 0);

        // Second request held on req_valid throughout the first rectangle.
        present(50, 60, 3, 3, 5);
        req_valid = 1'b1;
        step();
        present(100, 30, 1, 2, 2);
        expect_rect(50, 60, 3, 3, 5);
        step();
        req_valid = 1'b0;
        expect_rect(100, 30, 1, 2, 2);

        issue(158, 118, 3, 3, 6);
        expect_rect(158, 118, 3, 3, 6);

        repeat (6) begin
            rx = int'($urandom_range(0, 255));
            ry = int'($urandom_range(0, 127));
            rw = int'($urandom_range(0, 15));
            rh = int'($urandom_range(0, 5));
            rc = int'($urandom_range(0, 7));
            issue(rx, ry, rw, rh, rc);
            expect_rect(rx, ry, rw, rh, rc);
        end

        // Asynchronous reset in the middle of a 16x16.
        issue(30, 40, 15, 15, 5);
        for (int i = 0; i < 5; i++) begin
            chk("pre_rst_x", {24'd0, x}, 30 + i);
            chk("pre_rst_plot", {31'd0, plot}, 32'd1);
            step();
        end
        chk("px5_plot", {31'd0, plot}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_plot", {31'd0, plot}, 32'd0);
        chk("async_x", {24'd0, x}, 32'd0);
        chk("async_y", {25'd0, y}, 32'd0);
        chk("async_colour", {29'd0, colour}, 32'd0);
        chk("async_ready_busy", {30'd0, req_ready, busy}, 32'd2);
        repeat (3) begin
            step();
            chk("rst_no_done", {31'd0, done}, 32'd0);
        end
        resetn = 1'b1;
        step();
        chk("post_rst_no_done", {30'd0, done, plot}, 32'd0);
        issue(5, 6, 1, 1, 3);
        expect_rect(5, 6, 1, 1, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
